// File: rtl/dht11_sched_if.sv
// Signal bundle between the DHT11 read scheduler and its neighbours
// (UART RX byte stream, auto-poll enable, DHT11 FSM start/reset/result).
interface dht11_sched_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        auto_en;
    logic        sens_done;
    logic [39:0] sens_data;
    logic [7:0]  sens_start;
    logic        sens_rst;
    logic        busy;
    logic [7:0]  hum;
    logic [7:0]  temp;
    logic        data_valid;
    logic        err;
    logic        result_stb;

    modport slave (
        input  rx_data, rx_valid, auto_en, sens_done, sens_data,
        output sens_start, sens_rst, busy, hum, temp, data_valid, err, result_stb
    );

    modport master (
        output rx_data, rx_valid, auto_en, sens_done, sens_data,
        input  sens_start, sens_rst, busy, hum, temp, data_valid, err, result_stb
    );
endinterface

// File: rtl/dht11_scheduler.sv
// DHT11 read scheduler: merges UART and auto-poll requests, enforces the
// inter-read gap, times out and retries hung reads, latches the results.
module dht11_scheduler #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int MIN_GAP_MS = 1000,
    parameter int TIMEOUT_MS = 30,
    parameter int MAX_RETRY  = 2,
    parameter int POLL_MS    = 2000
) (
    input  logic         clk,
    input  logic         rst,
    dht11_sched_if.slave bus
);
    localparam int DIV    = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int PRE_W  = $clog2(DIV + 1);
    localparam int GAP_W  = (MIN_GAP_MS > 0) ? $clog2(MIN_GAP_MS + 1) : 1;
    localparam int TMO_W  = (TIMEOUT_MS > 0) ? $clog2(TIMEOUT_MS + 1) : 1;
    localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int POLL_W = (POLL_MS > 0) ? $clog2(POLL_MS + 1) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(MIN_GAP_MS);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT_MS);
    localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MS - 1);
    localparam logic [7:0]        START_BYTE = 8'h54;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_TRIG,
        S_WAIT,
        S_RECOVER,
        S_REPORT
    } state_e;

    state_e            state_q;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic [GAP_W-1:0]  gap_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [RTY_W-1:0]  retry_q;
    logic              rc_q;
    logic              pending_q;
    logic [7:0]        sens_start_q;
    logic              sens_rst_q;
    logic              busy_q;
    logic [7:0]        hum_q;
    logic [7:0]        temp_q;
    logic              data_valid_q;
    logic              err_q;
    logic              result_stb_q;

    logic ms_tick;
    logic cmd_req;
    logic auto_req;
    logic req;

    // Free-running 1 ms timebase and the auto-poll period counter.
    always_comb begin
        ms_tick  = (presc_q == PRE_LAST);
        presc_d  = ms_tick ? '0 : presc_q + 1'b1;
        auto_req = bus.auto_en && ms_tick && (poll_q == POLL_LAST);
        if (!bus.auto_en) begin
            poll_d = '0;
        end else if (ms_tick) begin
            poll_d = auto_req ? '0 : poll_q + 1'b1;
        end else begin
            poll_d = poll_q;
        end
        cmd_req = bus.rx_valid && (bus.rx_data == START_BYTE);
        req     = cmd_req || auto_req;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q <= '0;
            poll_q  <= '0;
        end else begin
            presc_q <= presc_d;
            poll_q  <= poll_d;
        end
    end

    // Read sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pending_q    <= 1'b0;
            retry_q      <= '0;
            rc_q         <= 1'b0;
            gap_q        <= '0;
            tmo_q        <= '0;
            sens_start_q <= 8'h00;
            sens_rst_q   <= 1'b1;
            busy_q       <= 1'b0;
            hum_q        <= 8'h00;
            temp_q       <= 8'h00;
            data_valid_q <= 1'b0;
            err_q        <= 1'b0;
            result_stb_q <= 1'b0;
        end else begin
            sens_start_q <= 8'h00;
            sens_rst_q   <= 1'b0;
            result_stb_q <= 1'b0;
            if (req) begin
                pending_q <= 1'b1;
            end
            if (ms_tick && (gap_q != GAP_MAX)) begin
                gap_q <= gap_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (pending_q) begin
                        // A request landing in this very cycle stays queued.
                        pending_q <= req;
                        retry_q   <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_MAX) begin
                        sens_start_q <= START_BYTE;
                        state_q      <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    gap_q   <= '0;
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (ms_tick && (tmo_q != TMO_MAX)) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                    if (bus.sens_done) begin
                        hum_q        <= bus.sens_data[39:32];
                        temp_q       <= bus.sens_data[23:16];
                        data_valid_q <= 1'b1;
                        err_q        <= 1'b0;
                        result_stb_q <= 1'b1;
                        state_q      <= S_REPORT;
                    end else if (tmo_q == TMO_MAX) begin
                        sens_rst_q <= 1'b1;
                        rc_q       <= 1'b0;
                        state_q    <= S_RECOVER;
                    end
                end
                S_RECOVER: begin
                    if (!rc_q) begin
                        sens_rst_q <= 1'b1;
                        rc_q       <= 1'b1;
                    end else if (retry_q < RTY_MAX) begin
                        retry_q <= retry_q + 1'b1;
                        state_q <= S_GAP;
                    end else begin
                        err_q        <= 1'b1;
                        result_stb_q <= 1'b1;
                        state_q      <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sens_start = sens_start_q;
    assign bus.sens_rst   = sens_rst_q;
    assign bus.busy       = busy_q;
    assign bus.hum        = hum_q;
    assign bus.temp       = temp_q;
    assign bus.data_valid = data_valid_q;
    assign bus.err        = err_q;
    assign bus.result_stb = result_stb_q;
endmodule

// File: tb/tb_dht11_scheduler.sv
// Bench for dht11_scheduler with scaled timing (10 cycles per ms); expected
// trigger, timeout and result times come from ms arithmetic on edge numbers.
module tb_dht11_scheduler;
    localparam int CLK_HZ     = 10_000;
    localparam int MIN_GAP_MS = 5;
    localparam int TIMEOUT_MS = 3;
    localparam int MAX_RETRY  = 1;
    localparam int POLL_MS    = 20;
    localparam int DIV        = CLK_HZ / 1000;
    localparam int GAP_CYC    = MIN_GAP_MS * DIV;

    logic clk = 1'b0;
    logic rst;

    dht11_sched_if bus();

    dht11_scheduler #(
        .CLK_HZ    (CLK_HZ),
        .MIN_GAP_MS(MIN_GAP_MS),
        .TIMEOUT_MS(TIMEOUT_MS),
        .MAX_RETRY (MAX_RETRY),
        .POLL_MS   (POLL_MS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int R           = 0;
    int trig_q[$];
    int rise_q[$];
    int fall_q[$];
    int stb_q[$];
    int start_bad   = 0;
    int stb_bad     = 0;
    logic [7:0] prev_start = 8'h00;
    logic       prev_rst   = 1'b0;
    logic       prev_stb   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled on the falling edge and events logged.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.sens_start == 8'h54) begin
            trig_q.push_back(cyc);
            if (prev_start == 8'h54) start_bad++;
        end else if (bus.sens_start != 8'h00) begin
            start_bad++;
        end
        if (bus.sens_rst && !prev_rst) rise_q.push_back(cyc);
        if (!bus.sens_rst && prev_rst) fall_q.push_back(cyc);
        if (bus.result_stb) begin
            stb_q.push_back(cyc);
            if (prev_stb) stb_bad++;
        end
        prev_start = bus.sens_start;
        prev_rst   = bus.sens_rst;
        prev_stb   = bus.result_stb;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        step();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    // Advance so that the next clock edge has number == m (mod DIV).
    task automatic align_edge(input int m);
        for (int i = 0; i < DIV; i++) begin
            if (((cyc - R + 1) % DIV) == m) break;
            step();
        end
    endtask

    function automatic int qsz(input int kind);
        case (kind)
            0: return trig_q.size();
            1: return rise_q.size();
            default: return stb_q.size();
        endcase
    endfunction

    function automatic int qat(input int kind, input int idx);
        case (kind)
            0: return trig_q[idx];
            1: return rise_q[idx];
            default: return stb_q[idx];
        endcase
    endfunction

    // kind: 0 = sens_start, 1 = sens_rst rise, 2 = result_stb. Returns edge rel. to R.
    task automatic wait_ev(input string tag, input int kind, input int budget, output int t);
        int n0;
        n0 = qsz(kind);
        t  = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (qsz(kind) > n0) begin
                t = qat(kind, n0) - R;
                break;
            end
        end
        vectors++;
        assert (t >= 0) else begin
            miscompares++;
            $error("FAIL %s observed=none expected=event within %0d cycles", tag, budget);
        end
    endtask

    // Earliest trigger edge: one edge after GAP is entered, and one edge after
    // the MIN_GAP_MS-th ms tick that follows the edge the gap was cleared on.
    function automatic int exp_trig(input int gap_entry_edge, input int clear_edge);
        int g;
        g = DIV * (clear_edge / DIV + MIN_GAP_MS);
        return (gap_entry_edge + 1 > g + 1) ? gap_entry_edge + 1 : g + 1;
    endfunction

    function automatic int exp_timeout(input int trig_edge);
        return DIV * ((trig_edge + 1) / DIV + TIMEOUT_MS) + 1;
    endfunction

    function automatic logic [39:0] mk_frame(input logic [7:0] h, input logic [7:0] hd,
                                             input logic [7:0] t, input logic [7:0] td);
        logic [7:0] ck;
        ck = h + hd + t + td;
        return {h, hd, t, td, ck};
    endfunction

    task automatic respond(input int dly, input logic [39:0] frame, output int s);
        repeat (dly) step();
        bus.sens_data = frame;
        bus.sens_done = 1'b1;
        step();
        bus.sens_done = 1'b0;
        s = cyc - R;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start"}, bus.sens_start, 8'h00);
        chk({tag, "_srst"},  bus.sens_rst, 1'b1);
        chk({tag, "_busy"},  bus.busy, 1'b0);
        chk({tag, "_hum"},   bus.hum, 8'h00);
        chk({tag, "_temp"},  bus.temp, 8'h00);
        chk({tag, "_dv"},    bus.data_valid, 1'b0);
        chk({tag, "_err"},   bus.err, 1'b0);
        chk({tag, "_stb"},   bus.result_stb, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t1, t2, t3, t4, s, rs, rs2, q, e, a, prev_t, prev_clear, n_trig, n_rise, n_stb, dly;
        logic [7:0] h, hd, tp, td;
        logic [39:0] fr;

        rst           = 1'b0;
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.auto_en   = 1'b0;
        bus.sens_done = 1'b0;
        bus.sens_data = 40'h0;
        repeat (5) step();
        chk_reset_outputs("reset");

        // Release with a "T" arriving on the very first cycle.
        bus.rx_data  = 8'h54;
        bus.rx_valid = 1'b1;
        rst          = 1'b1;
        R            = cyc;
        step();
        bus.rx_valid = 1'b0;
        chk("srst_release", bus.sens_rst, 1'b0);
        step();
        chk("busy_after_req", bus.busy, 1'b1);
        wait_ev("trig1", 0, 100, t);
        chk("trig1_edge", t, exp_trig(2, 0));
        chk("trig1_gap", t >= GAP_CYC, 1'b1);
        chk("trig1_only", trig_q.size(), 1);
        step();
        chk("start_1cyc", bus.sens_start, 8'h00);

        // Successful read with the reference frame.
        respond($urandom_range(0, 15), 40'h3700_1A00_51, s);
        chk("ok_stb", bus.result_stb, 1'b1);
        chk("ok_hum", bus.hum, 8'h37);
        chk("ok_temp", bus.temp, 8'h1A);
        chk("ok_dv", bus.data_valid, 1'b1);
        chk("ok_err", bus.err, 1'b0);
        step();
        chk("ok_stb_drop", bus.result_stb, 1'b0);
        chk("ok_busy_drop", bus.busy, 1'b0);
        prev_clear = t + 1;

        // sens_done while idle must be ignored.
        n_stb = stb_q.size();
        bus.sens_data = 40'hFF_FF_FF_FF_FF;
        bus.sens_done = 1'b1;
        step();
        bus.sens_done = 1'b0;
        step();
        chk("idle_done_hum", bus.hum, 8'h37);
        chk("idle_done_stb", stb_q.size(), n_stb);
        chk("idle_done_busy", bus.busy, 1'b0);

        // Hung sensor: timeout, recover, retry, final failure.
        n_rise = rise_q.size();
        align_edge(DIV - 1);
        send_byte(8'h54);
        q = cyc - R;
        wait_ev("to_trig1", 0, 200, t1);
        chk("to_trig1_edge", t1, exp_trig(q + 1, prev_clear));
        wait_ev("to_rise1", 1, 100, rs);
        chk("to_rise1_edge", rs, exp_timeout(t1));
        wait_ev("to_trig2", 0, 200, t2);
        chk("to_trig2_edge", t2, exp_trig(rs + 2, t1 + 1));
        chk("to_trig2_gap", (t2 - t1) >= GAP_CYC, 1'b1);
        chk("to_rise1_width", fall_q[n_rise] - rise_q[n_rise], 2);
        wait_ev("to_rise2", 1, 100, rs2);
        chk("to_rise2_edge", rs2, exp_timeout(t2));
        wait_ev("to_stb", 2, 20, s);
        chk("to_stb_edge", s, rs2 + 2);
        chk("to_err", bus.err, 1'b1);
        chk("to_hum_kept", bus.hum, 8'h37);
        chk("to_temp_kept", bus.temp, 8'h1A);
        chk("to_dv_kept", bus.data_valid, 1'b1);
        chk("to_rise2_width", fall_q[n_rise + 1] - rise_q[n_rise + 1], 2);
        prev_clear = t2 + 1;

        // Requests while busy merge into exactly one follow-up read.
        align_edge(DIV - 1);
        send_byte(8'h54);
        q = cyc - R;
        wait_ev("mg_trig1", 0, 200, t3);
        chk("mg_trig1_edge", t3, exp_trig(q + 1, prev_clear));
        repeat (2) step();
        send_byte(8'h54);
        step();
        send_byte(8'h41);
        send_byte(8'h54);
        h = 8'($urandom); hd = 8'($urandom); tp = 8'($urandom); td = 8'($urandom);
        respond($urandom_range(0, 8), mk_frame(h, hd, tp, td), s);
        chk("mg_hum1", bus.hum, h);
        chk("mg_temp1", bus.temp, tp);
        chk("mg_err1", bus.err, 1'b0);
        wait_ev("mg_trig2", 0, 200, t4);
        chk("mg_trig2_edge", t4, exp_trig(s + 2, t3 + 1));
        chk("mg_trig2_gap", (t4 - t3) >= GAP_CYC, 1'b1);
        step();
        h = 8'($urandom); hd = 8'($urandom); tp = 8'($urandom); td = 8'($urandom);
        respond($urandom_range(0, 10), mk_frame(h, hd, tp, td), s);
        chk("mg_hum2", bus.hum, h);
        chk("mg_temp2", bus.temp, tp);
        n_trig = trig_q.size();
        repeat (100) step();
        chk("mg_no_third", trig_q.size(), n_trig);
        prev_clear = t4 + 1;

        // Auto-poll: a trigger every POLL_MS, stopping once auto_en drops.
        bus.auto_en = 1'b1;
        step();
        e = cyc - R;
        a = DIV * ((e + DIV - 1) / DIV) + (POLL_MS - 1) * DIV;
        prev_t = 0;
        for (int k = 0; k < 3; k++) begin
            wait_ev("ap_trig", 0, POLL_MS * DIV + 50, t);
            chk("ap_trig_edge", t, exp_trig(a + k * POLL_MS * DIV + 1, prev_clear));
            if (k > 0) chk("ap_spacing", t - prev_t, POLL_MS * DIV);
            prev_t     = t;
            prev_clear = t + 1;
            step();
            h = 8'($urandom); hd = 8'($urandom); tp = 8'($urandom); td = 8'($urandom);
            respond($urandom_range(0, 12), mk_frame(h, hd, tp, td), s);
            chk("ap_hum", bus.hum, h);
            chk("ap_temp", bus.temp, tp);
        end
        bus.auto_en = 1'b0;
        n_trig = trig_q.size();
        repeat (450) step();
        chk("ap_stopped", trig_q.size(), n_trig);

        // Reset in the middle of WAIT aborts silently.
        send_byte(8'h54);
        q = cyc - R;
        wait_ev("rr_trig", 0, 100, t);
        chk("rr_trig_edge", t, exp_trig(q + 1, prev_clear));
        repeat (3) step();
        n_stb = stb_q.size();
        rst = 1'b0;
        repeat (2) step();
        chk_reset_outputs("midreset");
        bus.rx_data  = 8'h54;
        bus.rx_valid = 1'b1;
        rst          = 1'b1;
        R            = cyc;
        step();
        bus.rx_valid = 1'b0;
        chk("rr_srst_release", bus.sens_rst, 1'b0);
        wait_ev("rr_trig2", 0, 100, t);
        chk("rr_trig2_edge", t, exp_trig(2, 0));
        chk("rr_trig2_gap", t >= GAP_CYC, 1'b1);
        chk("rr_no_stb", stb_q.size(), n_stb);
        dly = $urandom_range(0, 10);
        step();
        h = 8'($urandom); hd = 8'($urandom); tp = 8'($urandom); td = 8'($urandom);
        respond(dly, mk_frame(h, hd, tp, td), s);
        chk("rr_hum", bus.hum, h);
        chk("rr_dv", bus.data_valid, 1'b1);
        step();

        chk("start_shape", start_bad, 0);
        chk("stb_shape", stb_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dht11_scheduler.md
Name: dht11_scheduler

Overview:
- Sequences the DHT11 read FSM. Read requests come from a UART command byte and from an optional periodic auto-poll timer.
- Enforces the sensor's minimum inter-read gap, times out hung transactions, resets and retries the FSM, and latches humidity/temperature results for display and UART reporting.
- Sits between the UART RX path and the DHT11 top, and drives that block's start byte and reset.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency; sets the 1 ms timebase divisor (CLK_HZ/1000 cycles per ms tick).
- MIN_GAP_MS, 1000, minimum ms from reset or previous trigger to the next trigger.
- TIMEOUT_MS, 30, ms allowed from trigger to sens_done before the read is declared failed.
- MAX_RETRY, 2, retries after the first failed attempt (MAX_RETRY+1 attempts total).
- POLL_MS, 2000, auto-poll request period in ms.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
- rx_data  in  8  UART received byte
- rx_valid  in  1  1-cycle strobe qualifying rx_data
- auto_en  in  1  enables periodic auto-poll requests
- sens_done  in  1  1-cycle pulse from the DHT11 FSM: checksum-valid frame captured
- sens_data  in  40  DHT11 frame {hum_int, hum_dec, tmp_int, tmp_dec, checksum}
- sens_start  out  8  start byte to the DHT11 FSM: 8'h54 ("T") for exactly 1 cycle, else 8'h00
- sens_rst  out  1  active-high reset to the DHT11 FSM
- busy  out  1  high in any state other than IDLE
- hum  out  8  latched humidity integer part
- temp  out  8  latched temperature integer part
- data_valid  out  1  high once any read has succeeded; stays high until reset
- err  out  1  outcome of the last completed request: 1 = all attempts failed
- result_stb  out  1  1-cycle pulse when a request completes, success or failure

Behaviour:
- Reset (rst=0 at posedge):
  - Outputs: sens_start=0, sens_rst=1, busy=0, hum=0, temp=0, data_valid=0, err=0, result_stb=0.
  - Internal: state=IDLE, pending=0, retry=0, gap_cnt=0, poll_cnt=0, ms prescaler=0.
  - A reset mid-transaction aborts it with no result_stb. sens_rst deasserts on the first cycle after rst=1.
- Timebase:
  - ms_tick pulses 1 cycle every CLK_HZ/1000 clocks.
  - gap_cnt increments on ms_tick and saturates at MIN_GAP_MS; it is cleared on every trigger.
  - poll_cnt counts only while auto_en=1; it is cleared when auto_en=0.
- Request sources:
  - cmd_req = rx_valid & (rx_data==8'h54). Any other byte is ignored.
  - auto_req = ms_tick when poll_cnt reaches POLL_MS-1, with auto_en=1; poll_cnt then wraps to 0.
  - Both sources set a 1-deep pending flag, in any state. Simultaneous or repeated requests merge into one read.
- State machine:
  - IDLE: if pending, clear pending and retry, go to GAP.
  - GAP: wait until gap_cnt==MIN_GAP_MS, then go to TRIG.
  - TRIG: drive sens_start=8'h54 for 1 cycle, clear gap_cnt and tmo_cnt, go to WAIT.
  - WAIT: tmo_cnt increments on ms_tick.
    - On sens_done: latch hum=sens_data[39:32] and temp=sens_data[23:16]; set data_valid=1, err=0; go to REPORT.
    - Else if tmo_cnt==TIMEOUT_MS: go to RECOVER.
    - sens_done and the timeout in the same cycle: sens_done wins.
  - RECOVER: hold sens_rst=1 for 2 cycles.
    - If retry<MAX_RETRY: retry+1, go to GAP; the gap is re-enforced and measured from the failed trigger.
    - Else: set err=1 (hum/temp keep previous values), go to REPORT.
  - REPORT: result_stb=1 for 1 cycle, go to IDLE.
- Handshake timing:
  - A request arriving while busy is serviced immediately after the current REPORT, via IDLE then GAP.
  - Minimum request-to-trigger latency is 2 cycles: pending set, then IDLE, then GAP with the gap already satisfied, then TRIG.
- Widths and counters:
  - Counters are sized with $clog2 of their terminal value +1. No wrap except poll_cnt.
  - sens_done outside WAIT is ignored.

Test Plan (CLK_HZ=10_000, MIN_GAP_MS=5, TIMEOUT_MS=3, MAX_RETRY=1, POLL_MS=20):
- Reset hold, then rx "T" at cycle 0 → no sens_start before 50 cycles after reset. Then one 1-cycle 8'h54 pulse; busy=1 from the cycle after the request.
- After the trigger, pulse sens_done with sens_data=40'h3700_1A00_51 → hum=8'h37, temp=8'h1A, data_valid=1, err=0, result_stb 1 cycle, busy=0.
- Never pulse sens_done → sens_rst 2-cycle pulse about 30 cycles after trigger 1. Second trigger ≥50 cycles after the first. Second sens_rst, then result_stb with err=1; hum/temp unchanged.
- Send rx "T" twice during WAIT plus one non-"T" byte, then complete the read → exactly one extra read follows, its trigger ≥50 cycles after the previous trigger.
- auto_en=1, sens_done returned each read → triggers spaced 200 cycles apart. Drop auto_en → no further triggers.
- Assert rst=0 during WAIT, then release → no result_stb; all outputs at reset values. A new "T" is honoured only after the 50-cycle gap.
